sd_sector_reader: RTL and testbench

- Read-direction counterpart of the top-level SD writer FSM.
- On a start pulse it issues one single-sector read to sdcard_interface and captures the 512 returned bytes into an on-chip buffer.
- It then streams the buffer out through the UART_TX handshake, so the uart command path can dump a sector to the host.

---
 rtl/sd_rd_pkg.sv | 23 ++
 rtl/sd_sector_reader_sector_buf.sv | 24 ++
 rtl/sd_sector_reader.sv | 208 ++++++++++++++++++++
 tb/tb_sd_sector_reader.sv | 325 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sd_rd_pkg.sv
// Shared types and constants for the SD sector reader.
package sd_rd_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    REQ     = 3'd1,
    FILL    = 3'd2,
    SEND    = 3'd3,
    WAIT_TX = 3'd4
  } state_t;

  localparam int unsigned DEF_SECTOR_BYTES = 512;

  localparam logic [7:0] ASCII_CR = 8'h0D;
  localparam logic [7:0] ASCII_LF = 8'h0A;

  // Nibble to uppercase ASCII hex digit.
  function automatic logic [7:0] hex_ascii(input logic [3:0] nib);
    if (nib < 4'd10) return 8'h30 + {4'h0, nib};
    else             return 8'h37 + {4'h0, nib};
  endfunction

endpackage

// File: rtl/sd_sector_reader_sector_buf.sv
// Simple dual-port sector RAM with a registered 1-cycle read port.
module sector_buf
  import sd_rd_pkg::*;
#(
  parameter int unsigned DEPTH = DEF_SECTOR_BYTES,
  parameter int unsigned AW    = $clog2(DEF_SECTOR_BYTES)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [7:0]    wdata,
  input  logic [AW-1:0] raddr,
  output logic [7:0]    rdata
);

  logic [7:0] mem [DEPTH];

  // Write port and registered read; no reset so the array maps to block RAM.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/sd_sector_reader.sv
// Reads one SD sector into a local buffer and streams it out over UART_TX.
// Optional build macro SD_READER_HEX_DUMP_EN: send each byte as two ASCII hex
// characters with CR/LF after every 16 bytes instead of raw binary.
module sd_sector_reader
  import sd_rd_pkg::*;
#(
  parameter int unsigned SECTOR_BYTES = DEF_SECTOR_BYTES,
  parameter logic [23:0] TIMEOUT_CYC  = 24'd12_000_000,
  parameter int unsigned CNT_W        = $clog2(SECTOR_BYTES) + 1
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        start,
  input  logic [31:0] sector,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [31:0] sd_raddr,
  output logic        sd_rena,
  input  logic        sd_rready,
  input  logic        sd_rvalid,
  input  logic [7:0]  sd_rdata,
  output logic        tx_dv,
  output logic [7:0]  tx_byte,
  input  logic        tx_active,
  input  logic        tx_done
);

  localparam int unsigned      AW      = CNT_W - 1;
  localparam logic [CNT_W-1:0] FULL    = CNT_W'(SECTOR_BYTES);
  localparam logic [23:0]      TO_LAST = TIMEOUT_CYC - 24'd1;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] wcnt, wcnt_nxt;
  logic [CNT_W-1:0] rcnt, rcnt_nxt;
  logic [23:0]      tcnt, tcnt_nxt;
  logic             rd_pend, rd_pend_nxt;
  logic             busy_nxt, done_nxt, err_nxt, rena_nxt, dv_nxt;
  logic [31:0]      raddr_nxt;
  logic [7:0]       byte_nxt;
  logic [7:0]       rd_data;
  logic             we;
`ifdef SD_READER_HEX_DUMP_EN
  logic [1:0]       ph, ph_nxt;   // 0: hi nibble, 1: lo nibble, 2: CR, 3: LF
`endif

  sector_buf #(
    .DEPTH (SECTOR_BYTES),
    .AW    (AW)
  ) u_buf (
    .clk   (clk),
    .we    (we),
    .waddr (wcnt[AW-1:0]),
    .wdata (sd_rdata),
    .raddr (rcnt[AW-1:0]),
    .rdata (rd_data)
  );

  // Next-state, counter and output decode.
  always_comb begin
    state_nxt   = state;
    wcnt_nxt    = wcnt;
    rcnt_nxt    = rcnt;
    tcnt_nxt    = tcnt;
    rd_pend_nxt = rd_pend;
    raddr_nxt   = sd_raddr;
    byte_nxt    = tx_byte;
    rena_nxt    = 1'b0;
    dv_nxt      = 1'b0;
    done_nxt    = 1'b0;
    err_nxt     = 1'b0;
    we          = 1'b0;
`ifdef SD_READER_HEX_DUMP_EN
    ph_nxt      = ph;
`endif
    unique case (state)
      IDLE: begin
        if (start) begin
          raddr_nxt   = sector;
          wcnt_nxt    = '0;
          rcnt_nxt    = '0;
          tcnt_nxt    = '0;
          rd_pend_nxt = 1'b0;
`ifdef SD_READER_HEX_DUMP_EN
          ph_nxt      = 2'd0;
`endif
          state_nxt   = REQ;
        end
      end
      REQ: begin
        if (tcnt == TO_LAST) begin
          err_nxt   = 1'b1;
          state_nxt = IDLE;
        end else begin
          tcnt_nxt = tcnt + 24'd1;
          if (sd_rready) begin
            rena_nxt  = 1'b1;
            state_nxt = FILL;
          end
        end
      end
      FILL: begin
        if (tcnt == TO_LAST) begin
          err_nxt   = 1'b1;
          state_nxt = IDLE;
        end else begin
          tcnt_nxt = tcnt + 24'd1;
          if (wcnt == FULL) begin
            rcnt_nxt    = '0;
            rd_pend_nxt = 1'b0;
            state_nxt   = SEND;
          end else if (sd_rvalid) begin
            we       = 1'b1;
            wcnt_nxt = wcnt + CNT_W'(1);
          end
        end
      end
      SEND: begin
        // First cycle issues the RAM read; second cycle launches the character.
        if (rd_pend) begin
          rd_pend_nxt = 1'b0;
          dv_nxt      = 1'b1;
          state_nxt   = WAIT_TX;
`ifdef SD_READER_HEX_DUMP_EN
          unique case (ph)
            2'd0:    byte_nxt = hex_ascii(rd_data[7:4]);
            2'd1:    byte_nxt = hex_ascii(rd_data[3:0]);
            2'd2:    byte_nxt = ASCII_CR;
            default: byte_nxt = ASCII_LF;
          endcase
`else
          byte_nxt    = rd_data;
`endif
        end else if (!tx_active) begin
          rd_pend_nxt = 1'b1;
        end
      end
      WAIT_TX: begin
        if (tx_done) begin
          state_nxt = SEND;
`ifdef SD_READER_HEX_DUMP_EN
          unique case (ph)
            2'd0: ph_nxt = 2'd1;
            2'd1: begin
              rcnt_nxt = rcnt + CNT_W'(1);
              ph_nxt   = (rcnt[3:0] == 4'hF) ? 2'd2 : 2'd0;
            end
            2'd2: ph_nxt = 2'd3;
            default: begin
              ph_nxt = 2'd0;
              if (rcnt == FULL) begin
                done_nxt  = 1'b1;
                state_nxt = IDLE;
              end
            end
          endcase
`else
          rcnt_nxt = rcnt + CNT_W'(1);
          if (rcnt_nxt == FULL) begin
            done_nxt  = 1'b1;
            state_nxt = IDLE;
          end
`endif
        end
      end
      default: state_nxt = IDLE;
    endcase
    busy_nxt = (state_nxt != IDLE);
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state    <= IDLE;
      wcnt     <= '0;
      rcnt     <= '0;
      tcnt     <= '0;
      rd_pend  <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
      sd_rena  <= 1'b0;
      sd_raddr <= '0;
      tx_dv    <= 1'b0;
      tx_byte  <= '0;
`ifdef SD_READER_HEX_DUMP_EN
      ph       <= 2'd0;
`endif
    end else begin
      state    <= state_nxt;
      wcnt     <= wcnt_nxt;
      rcnt     <= rcnt_nxt;
      tcnt     <= tcnt_nxt;
      rd_pend  <= rd_pend_nxt;
      busy     <= busy_nxt;
      done     <= done_nxt;
      err      <= err_nxt;
      sd_rena  <= rena_nxt;
      sd_raddr <= raddr_nxt;
      tx_dv    <= dv_nxt;
      tx_byte  <= byte_nxt;
`ifdef SD_READER_HEX_DUMP_EN
      ph       <= ph_nxt;
`endif
    end
  end

endmodule

// File: tb/tb_sd_sector_reader.sv
// Bench for sd_sector_reader: directed scenarios, SD and UART responders, and
// a per-cycle checker against an expected character stream.
// Honours SD_READER_HEX_DUMP_EN to expect the hex-dump character stream.
module tb_sd_sector_reader;

  localparam int SB = 512;
`ifdef SD_READER_HEX_DUMP_EN
  localparam int NCH = 1088;
`else
  localparam int NCH = 512;
`endif

  logic        clk = 1'b0;
  logic        rstn, start;
  logic [31:0] sector;
  logic        busy, done, err, sd_rena, tx_dv;
  logic [31:0] sd_raddr;
  logic [7:0]  tx_byte;
  logic        sd_rready, sd_rvalid, tx_active, tx_done;
  logic [7:0]  sd_rdata;
  logic        rready_block, hold_active, uart_busy;

  assign sd_rready = !rready_block;
  assign tx_active = uart_busy | hold_active;

  always #5 clk = ~clk;

  sd_sector_reader #(.TIMEOUT_CYC(24'd1000)) dut (
    .clk       (clk),
    .rstn      (rstn),
    .start     (start),
    .sector    (sector),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .sd_raddr  (sd_raddr),
    .sd_rena   (sd_rena),
    .sd_rready (sd_rready),
    .sd_rvalid (sd_rvalid),
    .sd_rdata  (sd_rdata),
    .tx_dv     (tx_dv),
    .tx_byte   (tx_byte),
    .tx_active (tx_active),
    .tx_done   (tx_done)
  );

  logic [7:0]  data [SB];
  int          ret_n = 512;

  // SD card responder: after a read strobe, return ret_n bytes back to back.
  initial begin
    sd_rvalid = 1'b0;
    sd_rdata  = 8'h00;
    forever begin
      @(posedge clk); #1;
      if (sd_rena) begin
        @(posedge clk); #1;
        for (int i = 0; i < ret_n; i++) begin
          sd_rvalid = 1'b1;
          sd_rdata  = data[i];
          @(posedge clk); #1;
        end
        sd_rvalid = 1'b0;
      end
    end
  end

  // UART_TX responder: busy for 3 cycles, then a 1-cycle tx_done.
  initial begin
    uart_busy = 1'b0;
    tx_done   = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (tx_dv) begin
        uart_busy = 1'b1;
        repeat (3) begin @(posedge clk); #1; end
        uart_busy = 1'b0;
        tx_done   = 1'b1;
        @(posedge clk); #1;
        tx_done   = 1'b0;
      end
    end
  end

  int          n_cmp = 0, n_bad = 0;
  int          cyc = 0;
  logic [7:0]  exp_q[$];
  logic [31:0] exp_addr;
  bit          model_busy = 1'b0, pend_start = 1'b0, prev_rready = 1'b1;
  int          rena_cnt, rv_cnt, tx_cnt, done_cnt, err_cnt;
  int          rena_cyc, err_cyc, last_txd, st_cyc, rel_cyc;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (tick %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic fail_now(input string nm);
    n_cmp++;
    n_bad++;
    $display("FAIL %s (tick %0d)", nm, cyc);
  endtask

  function automatic logic [7:0] hexc(input logic [3:0] n);
    return (n < 4'd10) ? 8'h30 + 8'(n) : 8'h41 + 8'(n) - 8'd10;
  endfunction

  // Expected character stream for the current sector contents.
  task automatic build_exp();
    exp_q.delete();
    for (int i = 0; i < SB; i++) begin
`ifdef SD_READER_HEX_DUMP_EN
      exp_q.push_back(hexc(data[i][7:4]));
      exp_q.push_back(hexc(data[i][3:0]));
      if (i % 16 == 15) begin
        exp_q.push_back(8'h0D);
        exp_q.push_back(8'h0A);
      end
`else
      exp_q.push_back(data[i]);
`endif
    end
  endtask

  // One clock: check outputs at the falling edge, return just after the rising edge.
  task automatic tick();
    @(negedge clk);
    cyc++;
    if (!rstn) begin
      model_busy = 1'b0;
      pend_start = 1'b0;
    end else begin
      if (pend_start) begin model_busy = 1'b1; pend_start = 1'b0; end
      if (done || err) model_busy = 1'b0;
      chk("busy", 32'(busy), 32'(model_busy));
      if (start && !model_busy) pend_start = 1'b1;
      if (sd_rena) begin
        rena_cnt++;
        rena_cyc = cyc;
        chk("rena_addr", sd_raddr, exp_addr);
        chk("rena_after_ready", 32'(prev_rready), 32'd1);
      end
      if (sd_rvalid) rv_cnt++;
      if (tx_done) last_txd = cyc;
      if (tx_dv) begin
        tx_cnt++;
        chk("tx_dv_while_active", 32'(hold_active), 32'd0);
        if (exp_q.size() == 0) fail_now("tx_dv_unexpected");
        else chk("tx_byte", 32'(tx_byte), 32'(exp_q.pop_front()));
      end
      if (done) begin
        done_cnt++;
        chk("done_all_sent", 32'(exp_q.size()), 32'd0);
        chk("done_latency", 32'(cyc - last_txd), 32'd1);
        chk("done_err_excl", 32'(err), 32'd0);
      end
      if (err) begin
        err_cnt++;
        err_cyc = cyc;
      end
    end
    prev_rready = sd_rready;
    @(posedge clk); #1;
  endtask

  task automatic do_start(input logic [31:0] s, input bit full);
    rena_cnt = 0; rv_cnt = 0; tx_cnt = 0; done_cnt = 0; err_cnt = 0;
    exp_addr = s;
    if (full) build_exp();
    else exp_q.delete();
    sector = s;
    start  = 1'b1;
    tick();
    st_cyc = cyc;
    start  = 1'b0;
    sector = 32'h0;
  endtask

  task automatic wait_end(input int budget);
    int n = 0;
    while (done_cnt == 0 && err_cnt == 0 && n < budget) begin
      tick();
      n++;
    end
    if (n >= budget) fail_now("wait_end_timeout");
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_busy"},     32'(busy),    32'd0);
    chk({tag, "_done"},     32'(done),    32'd0);
    chk({tag, "_err"},      32'(err),     32'd0);
    chk({tag, "_sd_rena"},  32'(sd_rena), 32'd0);
    chk({tag, "_tx_dv"},    32'(tx_dv),   32'd0);
    chk({tag, "_sd_raddr"}, sd_raddr,     32'd0);
    chk({tag, "_tx_byte"},  32'(tx_byte), 32'd0);
  endtask

  initial begin
    int n;
    rstn = 1'b0; start = 1'b0; sector = 32'h0;
    rready_block = 1'b0; hold_active = 1'b0;
    for (int i = 0; i < SB; i++) data[i] = 8'(i);
`ifdef SD_READER_HEX_DUMP_EN
    data[0] = 8'hA5;
`endif
    repeat (3) @(posedge clk);
    #1;
    chk_reset("rst");
    rstn = 1'b1;
    repeat (2) tick();

    // Pin the expected-stream model with hand-computed characters.
    build_exp();
`ifdef SD_READER_HEX_DUMP_EN
    chk("pin_size",  32'(exp_q.size()), 32'd1088);
    chk("pin_hi_A5", 32'(exp_q[0]),     32'h41);
    chk("pin_lo_A5", 32'(exp_q[1]),     32'h35);
    chk("pin_byte1", 32'(exp_q[3]),     32'h31);
    chk("pin_cr",    32'(exp_q[32]),    32'h0D);
    chk("pin_lf",    32'(exp_q[33]),    32'h0A);
    chk("pin_ff_hi", 32'(exp_q[34*15+30]), 32'h46);
    chk("pin_last",  32'(exp_q[1087]),  32'h0A);
`else
    chk("pin_size",  32'(exp_q.size()), 32'd512);
    chk("pin_0",     32'(exp_q[0]),     32'h00);
    chk("pin_255",   32'(exp_q[255]),   32'hFF);
    chk("pin_256",   32'(exp_q[256]),   32'h00);
    chk("pin_511",   32'(exp_q[511]),   32'hFF);
`endif

    // Single read of sector 2052.
    do_start(32'd2052, 1'b1);
    wait_end(20000);
    chk("s1_rena_cnt", 32'(rena_cnt), 32'd1);
    chk("s1_rv_cnt",   32'(rv_cnt),   32'd512);
    chk("s1_tx_cnt",   32'(tx_cnt),   32'(NCH));
    chk("s1_done_cnt", 32'(done_cnt), 32'd1);
    chk("s1_err_cnt",  32'(err_cnt),  32'd0);
    chk("s1_busy_end", 32'(busy),     32'd0);
    repeat (3) tick();

    // Backpressure on both the SD and UART side.
    rready_block = 1'b1;
    do_start(32'd2052, 1'b1);
    repeat (100) tick();
    chk("s2_no_rena_blocked", 32'(rena_cnt), 32'd0);
    rel_cyc = cyc;
    rready_block = 1'b0;
    n = 0;
    while (rv_cnt < 512 && n < 3000) begin tick(); n++; end
    if (n >= 3000) fail_now("s2_fill_timeout");
    hold_active = 1'b1;
    repeat (50) tick();
    chk("s2_no_tx_while_active", 32'(tx_cnt), 32'd0);
    hold_active = 1'b0;
    wait_end(20000);
    // Release lands after tick rel_cyc; DUT sees it one tick later and strobes the next.
    chk("s2_rena_latency", 32'(rena_cyc - rel_cyc), 32'd2);
    chk("s2_rena_cnt",     32'(rena_cnt), 32'd1);
    chk("s2_tx_cnt",       32'(tx_cnt),   32'(NCH));
    chk("s2_done_cnt",     32'(done_cnt), 32'd1);
    repeat (3) tick();

    // Start while busy is ignored.
    do_start(32'd2052, 1'b1);
    n = 0;
    while (rv_cnt < 5 && n < 100) begin tick(); n++; end
    if (n >= 100) fail_now("s4_fill_start_timeout");
    sector = 32'd7;
    start  = 1'b1;
    tick();
    start  = 1'b0;
    sector = 32'h0;
    tick();
    chk("s4_raddr_held", sd_raddr, 32'd2052);
    wait_end(20000);
    chk("s4_rena_cnt", 32'(rena_cnt), 32'd1);
    chk("s4_done_cnt", 32'(done_cnt), 32'd1);
    chk("s4_tx_cnt",   32'(tx_cnt),   32'(NCH));
    repeat (3) tick();

    // Timeout: only 10 bytes returned.
    ret_n = 10;
    do_start(32'd2052, 1'b0);
    wait_end(2000);
    // Counter hits 999 on its 1000th REQ/FILL cycle; err registers on that edge.
    chk("s3_err_time", 32'(err_cyc - st_cyc), 32'd1001);
    chk("s3_err_cnt",  32'(err_cnt),  32'd1);
    chk("s3_done_cnt", 32'(done_cnt), 32'd0);
    chk("s3_tx_cnt",   32'(tx_cnt),   32'd0);
    chk("s3_rv_cnt",   32'(rv_cnt),   32'd10);
    chk("s3_busy",     32'(busy),     32'd0);
    ret_n = 512;
    repeat (3) tick();
    do_start(32'd2052, 1'b1);
    wait_end(20000);
    chk("s3b_done_cnt", 32'(done_cnt), 32'd1);
    chk("s3b_err_cnt",  32'(err_cnt),  32'd0);
    chk("s3b_tx_cnt",   32'(tx_cnt),   32'(NCH));
    repeat (3) tick();

    // Reset in the middle of SEND.
    do_start(32'd2052, 1'b1);
    n = 0;
    while (tx_cnt < 100 && n < 5000) begin tick(); n++; end
    if (n >= 5000) fail_now("s5_send_timeout");
    rstn = 1'b0;
    #1;
    chk_reset("s5");
    repeat (3) tick();
    rstn = 1'b1;
    exp_q.delete();
    repeat (20) tick();
    chk("s5_done_cnt", 32'(done_cnt), 32'd0);
    chk("s5_err_cnt",  32'(err_cnt),  32'd0);
    chk("s5_busy",     32'(busy),     32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
